// File: rtl/led_event_sched.sv
// Shared active-low RGB status LED arbiter: latches event pulses, shows each granted
// requester's colour for a hold time, then a dark gap; a sticky error overrides all.
module led_event_sched #(
    parameter int          HOLD_CYC   = 2400000,
    parameter int          GAP_CYC    = 240000,
    parameter int          BLINK_HALF = 300000,
    parameter int          CNT_W      = 24,
    parameter logic [2:0]  COL0       = 3'b010,
    parameter logic [2:0]  COL1       = 3'b001,
    parameter logic [2:0]  COL2       = 3'b011,
    parameter logic [2:0]  COL3       = 3'b110,
    parameter logic [2:0]  ERR_COL    = 3'b100
) (
    input  logic       i_clk,
    input  logic       i_res,
    input  logic [3:0] i_req,
    input  logic [2:0] i_bg_rgb,
    input  logic       i_err,
    input  logic       i_err_clr,
    output logic       o_led_r,
    output logic       o_led_g,
    output logic       o_led_b,
    output logic [3:0] o_grant,
    output logic       o_busy,
    output logic       o_err
);

    typedef enum logic [1:0] {IDLE, SHOW, GAP, ERROR} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'((BLINK_HALF == 0) ? 0 : BLINK_HALF - 1);

    state_t           state, state_nx;
    logic [3:0]       pend, clr;
    logic             err;
    logic [CNT_W-1:0] cnt, cnt_nx, bcnt, bcnt_nx;
    logic             phase, phase_nx;
    logic [1:0]       g, g_nx;
    logic [2:0]       colour;
    logic [3:0]       grant_nx;

    function automatic logic [1:0] top_bit(input logic [3:0] v);
        if (v[3])      return 2'd3;
        else if (v[2]) return 2'd2;
        else if (v[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    function automatic logic [2:0] col_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return COL0;
            2'd1:    return COL1;
            2'd2:    return COL2;
            default: return COL3;
        endcase
    endfunction

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        bcnt_nx  = bcnt;
        phase_nx = phase;
        g_nx     = g;
        clr      = '0;
        colour   = 3'b000;
        grant_nx = '0;
        case (state)
            IDLE: begin
                colour = i_bg_rgb;
                if (err) begin
                    state_nx = ERROR;
                    cnt_nx   = '0;
                end else if (pend != 4'b0000) begin
                    state_nx = SHOW;
                    g_nx     = top_bit(pend);
                    cnt_nx   = '0;
                    bcnt_nx  = '0;
                    phase_nx = 1'b1;
                end
            end
            SHOW: begin
                colour   = phase ? col_of(g) : 3'b000;
                grant_nx = 4'b0001 << g;
                // Error aborts the display but leaves pend[g] set so it is replayed later.
                if (err) begin
                    state_nx = ERROR;
                    cnt_nx   = '0;
                end else begin
                    if (BLINK_HALF != 0) begin
                        if (bcnt == BLINK_LAST) begin
                            bcnt_nx  = '0;
                            phase_nx = ~phase;
                        end else begin
                            bcnt_nx = bcnt + 1'b1;
                        end
                    end
                    if (cnt == HOLD_LAST) begin
                        clr[g]   = 1'b1;
                        state_nx = GAP;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            GAP: begin
                if (err) begin
                    state_nx = ERROR;
                    cnt_nx   = '0;
                end else if (cnt == GAP_LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                colour = ERR_COL;
                if (!err) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            state   <= IDLE;
            pend    <= '0;
            err     <= 1'b0;
            cnt     <= '0;
            bcnt    <= '0;
            phase   <= 1'b1;
            g       <= 2'd0;
            o_led_r <= 1'b1;
            o_led_g <= 1'b1;
            o_led_b <= 1'b1;
            o_grant <= '0;
            o_busy  <= 1'b0;
        end else begin
            state   <= state_nx;
            // A new pulse in the same cycle as its clear re-arms the request.
            pend    <= (pend & ~clr) | i_req;
            err     <= (err & ~i_err_clr) | i_err;
            cnt     <= cnt_nx;
            bcnt    <= bcnt_nx;
            phase   <= phase_nx;
            g       <= g_nx;
            {o_led_r, o_led_g, o_led_b} <= ~colour;
            o_grant <= grant_nx;
            o_busy  <= (state != IDLE);
        end
    end

    assign o_err = err;

endmodule

// File: tb/tb_led_event_sched.sv
// Directed bench for led_event_sched with HOLD_CYC=8, GAP_CYC=2, BLINK_HALF=2:
// a per-cycle vector table for scheduling cases plus hand sequences for error/reset.
module tb_led_event_sched;

    localparam logic [2:0] C0 = 3'b010, C1 = 3'b001, C2 = 3'b011, C3 = 3'b110;
    localparam logic [2:0] IL   = 3'b110;   // pins for background 3'b001
    localparam logic [2:0] OFF  = 3'b111;
    localparam logic [2:0] ERRP = 3'b011;   // pins for ERR_COL 3'b100

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [2:0] bg = 3'b001;
    logic       err_in = 1'b0;
    logic       err_clr = 1'b0;
    logic       led_r, led_g, led_b;
    logic [3:0] grant;
    logic       busy, err_out;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string      name;
        logic [3:0] req;
        logic [2:0] bg;
        logic [2:0] led;
        logic [3:0] grant;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    led_event_sched #(
        .HOLD_CYC(8), .GAP_CYC(2), .BLINK_HALF(2), .CNT_W(4)
    ) dut (
        .i_clk(clk), .i_res(rst), .i_req(req), .i_bg_rgb(bg),
        .i_err(err_in), .i_err_clr(err_clr),
        .o_led_r(led_r), .o_led_g(led_g), .o_led_b(led_b),
        .o_grant(grant), .o_busy(busy), .o_err(err_out)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] show_led(input int k, input logic [2:0] col);
        return (((k / 2) % 2) == 0) ? ~col : OFF;
    endfunction

    task automatic check(input string name, input logic [2:0] led, input logic [3:0] gr,
                         input logic b, input logic e);
        logic [8:0] act, exp;
        act = {led_r, led_g, led_b, grant, busy, err_out};
        exp = {led, gr, b, e};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got led=%b grant=%b busy=%b err=%b, want led=%b grant=%b busy=%b err=%b",
                     name, act[8:6], act[5:2], act[1], act[0], exp[8:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic step(input string name, input logic [3:0] r, input logic e, input logic c,
                        input logic [2:0] led, input logic [3:0] gr, input logic b, input logic ex);
        req = r; err_in = e; err_clr = c;
        @(posedge clk); #1;
        check(name, led, gr, b, ex);
        req = 4'b0000; err_in = 1'b0; err_clr = 1'b0;
    endtask

    task automatic add(input string name, input logic [3:0] r, input logic [2:0] b_rgb,
                       input logic [2:0] led, input logic [3:0] gr, input logic b);
        vec_t v;
        v.name = name; v.req = r; v.bg = b_rgb; v.led = led; v.grant = gr; v.busy = b;
        vecs.push_back(v);
    endtask

    task automatic add_idle(input string name, input int n);
        for (int i = 0; i < n; i++) add(name, 4'b0000, 3'b001, IL, 4'b0000, 1'b0);
    endtask

    task automatic add_show(input string name, input logic [3:0] gr, input logic [2:0] col);
        for (int k = 0; k < 8; k++) add(name, 4'b0000, 3'b001, show_led(k, col), gr, 1'b1);
    endtask

    task automatic add_gap(input string name);
        for (int i = 0; i < 2; i++) add(name, 4'b0000, 3'b001, OFF, 4'b0000, 1'b1);
    endtask

    task automatic hshow(input string name, input logic [3:0] gr, input logic [2:0] col,
                         input logic [3:0] last_req);
        for (int k = 0; k < 8; k++)
            step(name, (k == 7) ? last_req : 4'b0000, 1'b0, 1'b0, show_led(k, col), gr, 1'b1, 1'b0);
    endtask

    task automatic hgap(input string name);
        for (int i = 0; i < 2; i++) step(name, 4'b0000, 1'b0, 1'b0, OFF, 4'b0000, 1'b1, 1'b0);
    endtask

    task automatic hidle(input string name, input int n);
        for (int i = 0; i < n; i++) step(name, 4'b0000, 1'b0, 1'b0, IL, 4'b0000, 1'b0, 1'b0);
    endtask

    initial begin
        int base;

        // Vector table: idle/background, single event, simultaneous events, non-preemption.
        add_idle("t1_idle", 2);
        add("t1_bg", 4'b0000, 3'b110, 3'b001, 4'b0000, 1'b0);
        add_idle("t1_bg_back", 1);
        add("t2_pulse", 4'b0001, 3'b001, IL, 4'b0000, 1'b0);
        add_idle("t2_latch", 1);
        add_show("t2_show0", 4'b0001, C0);
        add_gap("t2_gap");
        add_idle("t2_done", 3);
        add("t3_pulse", 4'b0101, 3'b001, IL, 4'b0000, 1'b0);
        add_idle("t3_latch", 1);
        add_show("t3_show2", 4'b0100, C2);
        add_gap("t3_gap_a");
        add_idle("t3_idle_a", 1);
        add_show("t3_show0", 4'b0001, C0);
        add_gap("t3_gap_b");
        add_idle("t3_done", 2);
        add("t4_pulse", 4'b0001, 3'b001, IL, 4'b0000, 1'b0);
        add_idle("t4_latch", 1);
        base = vecs.size();
        add_show("t4_show0", 4'b0001, C0);
        vecs[base + 3].req = 4'b1000;
        add_gap("t4_gap_a");
        add_idle("t4_idle_a", 1);
        add_show("t4_show3", 4'b1000, C3);
        add_gap("t4_gap_b");
        add_idle("t4_done", 2);

        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", OFF, 4'b0000, 1'b0, 1'b0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            req = vecs[i].req; bg = vecs[i].bg; err_in = 1'b0; err_clr = 1'b0;
            @(posedge clk); #1;
            check(vecs[i].name, vecs[i].led, vecs[i].grant, vecs[i].busy, 1'b0);
        end
        req = 4'b0000; bg = 3'b001;

        // Error pulse in the middle of req1's display, then replay after clear.
        step("t5_pulse", 4'b0010, 1'b0, 1'b0, IL, 4'b0000, 1'b0, 1'b0);
        step("t5_latch", 4'b0000, 1'b0, 1'b0, IL, 4'b0000, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++)
            step("t5_show1", 4'b0000, 1'b0, 1'b0, show_led(k, C1), 4'b0010, 1'b1, 1'b0);
        step("t5_err_set", 4'b0000, 1'b1, 1'b0, show_led(3, C1), 4'b0010, 1'b1, 1'b1);
        step("t5_err_lat", 4'b0000, 1'b0, 1'b0, show_led(4, C1), 4'b0010, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++)
            step("t5_error", 4'b0000, 1'b0, 1'b0, ERRP, 4'b0000, 1'b1, 1'b1);
        step("t5_clr", 4'b0000, 1'b0, 1'b1, ERRP, 4'b0000, 1'b1, 1'b0);
        step("t5_leave", 4'b0000, 1'b0, 1'b0, ERRP, 4'b0000, 1'b1, 1'b0);
        step("t5_idle", 4'b0000, 1'b0, 1'b0, IL, 4'b0000, 1'b0, 1'b0);
        hshow("t5_reshow1", 4'b0010, C1, 4'b0000);
        hgap("t5_gap");
        hidle("t5_done", 2);

        // Set and clear together: set wins.
        step("t6_err_set", 4'b0000, 1'b1, 1'b0, IL, 4'b0000, 1'b0, 1'b1);
        step("t6_set_clr", 4'b0000, 1'b1, 1'b1, IL, 4'b0000, 1'b0, 1'b1);
        step("t6_error", 4'b0000, 1'b0, 1'b0, ERRP, 4'b0000, 1'b1, 1'b1);
        step("t6_clr", 4'b0000, 1'b0, 1'b1, ERRP, 4'b0000, 1'b1, 1'b0);
        step("t6_leave", 4'b0000, 1'b0, 1'b0, ERRP, 4'b0000, 1'b1, 1'b0);
        step("t6_idle", 4'b0000, 1'b0, 1'b0, IL, 4'b0000, 1'b0, 1'b0);

        // Re-request on the very cycle its own display completes.
        step("t6_pulse", 4'b0100, 1'b0, 1'b0, IL, 4'b0000, 1'b0, 1'b0);
        step("t6_latch", 4'b0000, 1'b0, 1'b0, IL, 4'b0000, 1'b0, 1'b0);
        hshow("t6_show2_a", 4'b0100, C2, 4'b0100);
        hgap("t6_gap_a");
        hidle("t6_idle_a", 1);
        hshow("t6_show2_b", 4'b0100, C2, 4'b0000);
        hgap("t6_gap_b");
        hidle("t6_done", 3);

        // Asynchronous reset mid-display drops the pending event.
        step("t7_pulse", 4'b1000, 1'b0, 1'b0, IL, 4'b0000, 1'b0, 1'b0);
        step("t7_latch", 4'b0000, 1'b0, 1'b0, IL, 4'b0000, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++)
            step("t7_show3", 4'b0000, 1'b0, 1'b0, show_led(k, C3), 4'b1000, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 check("t7_async_rst", OFF, 4'b0000, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        hidle("t7_after_rst", 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
